// File: rtl/merger_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | merger_pkg: defaults and tuple type shared by the merger buffer.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package merger_pkg;

  localparam int DATA_WIDTH_DEF = 128;
  localparam int DEPTH_DEF      = 16;
  localparam int AF_MARGIN_DEF  = 4;

  // One sorted tuple: upper element in the high half, lower in the low half.
  typedef logic [2*DATA_WIDTH_DEF-1:0] tuple_t;

endpackage
`default_nettype wire

// File: rtl/merger_fifo_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | merger_fifo_mem: tuple storage, one write port, one registered     |
// | read port.  Revision: 1.0                                          |
// +--------------------------------------------------------------------+
module merger_fifo_mem
  import merger_pkg::*;
#(
  parameter int WIDTH = 2*DATA_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Read returns the pre-write contents when addresses collide.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
    rdata_q <= mem_q[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/merger_output_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | merger_output_buffer: FWFT tuple FIFO with registered almost-full  |
// | stall request and sticky overflow.  Revision: 1.0                  |
// +--------------------------------------------------------------------+
module merger_output_buffer
  import merger_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AF_MARGIN  = AF_MARGIN_DEF,
  localparam int TW        = 2*DATA_WIDTH,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH)+1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_stall,
  input  logic [TW-1:0] i_elems,
  output logic          o_stall_req,
  output logic [TW-1:0] o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [CW-1:0] o_count,
  output logic          o_overflow
);

  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(DEPTH - AF_MARGIN);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic [TW-1:0] data_q, data_d;
  logic          stall_req_q, stall_req_d;
  logic          overflow_q, overflow_d;
  logic          byp_sel_q, byp_sel_d;
  logic [TW-1:0] byp_data_q, byp_data_d;

  logic          rd, wr, ovf, load_out, pop, direct, mem_we, mem_empty;
  logic [CW-1:0] mem_cnt;
  logic [TW-1:0] mem_rdata, head_mem;

  merger_fifo_mem #(
    .WIDTH (TW),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_elems),
    .i_raddr (rd_ptr_d),
    .o_rdata (mem_rdata)
  );

  // The read port is addressed with the next head pointer, so its output is
  // the current head unless that slot was written on the previous edge.
  assign head_mem = byp_sel_q ? byp_data_q : mem_rdata;

  always_comb begin
    rd        = valid_q & i_ready;
    wr        = ~i_stall & ((count_q != FULL_C) | rd);
    ovf       = ~i_stall & (count_q == FULL_C) & ~rd;
    mem_cnt   = count_q - {{(CW-1){1'b0}}, valid_q};
    mem_empty = (mem_cnt == '0);

    load_out  = ~valid_q | rd;
    pop       = load_out & ~mem_empty;
    direct    = load_out & mem_empty & wr;
    mem_we    = wr & ~direct;

    valid_d = valid_q;
    data_d  = data_q;
    if (load_out) begin
      valid_d = pop | direct;
      if (pop) begin
        data_d = head_mem;
      end else if (direct) begin
        data_d = i_elems;
      end
    end

    unique case ({wr, rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    rd_ptr_d    = rd_ptr_q + {{(AW-1){1'b0}}, pop};
    wr_ptr_d    = wr_ptr_q + {{(AW-1){1'b0}}, mem_we};
    byp_sel_d   = mem_we & (wr_ptr_q == rd_ptr_d);
    byp_data_d  = mem_we ? i_elems : byp_data_q;
    stall_req_d = (count_d >= THRESH_C);
    overflow_d  = overflow_q | ovf;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      stall_req_q <= 1'b0;
      overflow_q  <= 1'b0;
      byp_sel_q   <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      stall_req_q <= stall_req_d;
      overflow_q  <= overflow_d;
      byp_sel_q   <= byp_sel_d;
      byp_data_q  <= byp_data_d;
    end
  end

  assign o_stall_req = stall_req_q;
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_count     = count_q;
  assign o_overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_merger_output_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_merger_output_buffer: directed and randomised checks of the     |
// | merger output buffer.  Revision: 1.0                               |
// +--------------------------------------------------------------------+
module tb_merger_output_buffer;
  import merger_pkg::*;

  localparam int DW = DATA_WIDTH_DEF;
  localparam int TW = 2*DW;
  localparam int CW = $clog2(DEPTH_DEF)+1;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic [TW-1:0] elems;
  logic          ready;
  logic          stall_req;
  logic [TW-1:0] data;
  logic          valid;
  logic [CW-1:0] count;
  logic          overflow;

  int n_tests;
  int n_fail;

  merger_output_buffer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_stall     (stall),
    .i_elems     (elems),
    .o_stall_req (stall_req),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_count     (count),
    .o_overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tuple_t tup(input int v);
    return {DW'(v*2+1), DW'(v)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n);
    ready = 1'b0;
    for (int k = 1; k <= n; k++) begin
      stall = 1'b0;
      elems = tup(k);
      step();
    end
    stall = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"},    TW'(valid),     '0);
    check({tag, "_data"},     data,           '0);
    check({tag, "_count"},    TW'(count),     '0);
    check({tag, "_stallreq"}, TW'(stall_req), '0);
    check({tag, "_ovf"},      TW'(overflow),  '0);
  endtask

  tuple_t     exp_q[$];
  logic [2:0] sr_hist;
  logic       send;
  int         seq;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    stall   = 1'b1;
    ready   = 1'b0;
    elems   = '0;
    #1 rst_n = 1'b0;
    step();
    step();
    check_idle("reset");
    rst_n = 1'b1;
    step();
    check("post_reset_count", TW'(count), '0);

    // Single write into an empty buffer falls straight through.
    stall = 1'b0;
    elems = {DW'(5), DW'(3)};
    step();
    check("fwft_valid", TW'(valid), TW'(1));
    check("fwft_data",  data, {DW'(5), DW'(3)});
    check("fwft_count", TW'(count), TW'(1));
    stall = 1'b1;
    ready = 1'b1;
    step();
    check("single_read_valid", TW'(valid), '0);
    check("single_read_count", TW'(count), '0);

    // Fill to 16: almost-full asserts after the 12th write.
    ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      stall = 1'b0;
      elems = tup(k);
      step();
      check($sformatf("fill_stallreq_%0d", k), TW'(stall_req), TW'(k >= 12));
    end
    stall = 1'b1;
    check("full_count", TW'(count), TW'(16));
    check("full_ovf",   TW'(overflow), '0);
    ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("drain_valid_%0d", k), TW'(valid), TW'(1));
      check($sformatf("drain_data_%0d", k), data, tup(k));
      step();
    end
    check("drained_valid", TW'(valid), '0);
    check("drained_count", TW'(count), '0);
    step();
    check("underflow_count", TW'(count), '0);

    // Simultaneous read and write while full.
    fill(16);
    stall = 1'b0;
    elems = tup(100);
    ready = 1'b1;
    step();
    stall = 1'b1;
    check("rw_full_count", TW'(count), TW'(16));
    check("rw_full_ovf",   TW'(overflow), '0);
    for (int k = 2; k <= 16; k++) begin
      check($sformatf("rw_drain_%0d", k), data, tup(k));
      step();
    end
    check("rw_last_valid", TW'(valid), TW'(1));
    check("rw_last_data",  data, tup(100));
    step();
    check("rw_empty_valid", TW'(valid), '0);

    // Write into a full buffer without a read is dropped and flagged.
    fill(16);
    stall = 1'b0;
    elems = tup(200);
    step();
    stall = 1'b1;
    check("ovf_flag",  TW'(overflow), TW'(1));
    check("ovf_count", TW'(count), TW'(16));
    ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("ovf_drain_%0d", k), data, tup(k));
      step();
    end
    check("ovf_empty_valid", TW'(valid), '0);
    check("ovf_sticky",      TW'(overflow), TW'(1));

    // Asynchronous reset with tuples held.
    fill(7);
    check("pre_rst_count", TW'(count), TW'(7));
    #2 rst_n = 1'b0;
    #1;
    check_idle("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b1;
    ready = 1'b1;
    step();
    check("after_rst_valid", TW'(valid), '0);
    check("after_rst_count", TW'(count), '0);
    stall = 1'b0;
    elems = tup(42);
    step();
    stall = 1'b1;
    check("after_rst_write", data, tup(42));
    step();
    check("after_rst_empty", TW'(count), '0);

    // Random traffic; upstream stops three cycles after o_stall_req.
    sr_hist = '0;
    seq     = 1000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      send  = !sr_hist[2] && ($urandom_range(0, 3) != 0);
      stall = !send;
      elems = tup(seq);
      if (((cyc / 500) % 2) == 1) ready = ($urandom_range(0, 3) == 0);
      else                        ready = ($urandom_range(0, 3) != 0);
      if (valid && ready) begin
        if (exp_q.size() == 0) check("rand_unexpected", data, '0 - 1);
        else                   check("rand_data", data, exp_q.pop_front());
      end
      if (send) begin
        exp_q.push_back(tup(seq));
        seq++;
      end
      step();
      check("rand_count",    TW'(count), TW'(exp_q.size()));
      check("rand_stallreq", TW'(stall_req), TW'(exp_q.size() >= 12));
      sr_hist = {sr_hist[1:0], stall_req};
    end
    stall = 1'b1;
    ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (valid && exp_q.size() != 0) check("rand_tail", data, exp_q.pop_front());
      step();
    end
    check("rand_tail_left", TW'(exp_q.size()), '0);
    check("rand_ovf",       TW'(overflow), '0);
    check("rand_end_valid", TW'(valid), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/merger_output_buffer.md
MERGER_OUTPUT_BUFFER -- requirements
Module: merger_output_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 128, width of one element; one tuple is 2*DATA_WIDTH bits.
REQ-002 Parameter DEPTH, default 16, tuple entries; power of two and at least 8.
REQ-003 Parameter AF_MARGIN, default 4, free entries reserved to absorb in-flight tuples after stall request.
REQ-004 i_clk  in  1  single clock; all logic on posedge.
REQ-005 i_rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 i_stall  in  1  stall flag from bitonic network stage; low means i_elems carries a valid sorted tuple this cycle.
REQ-007 i_elems  in  2*DATA_WIDTH  lower (emitted) sorted tuple from network stage; upper element in [2*DW-1:DW].
REQ-008 o_stall_req  out  1  registered almost-full; drives upstream merger stall.
REQ-009 o_data  out  2*DATA_WIDTH  head tuple, registered.
REQ-010 o_valid  out  1  o_data holds a valid tuple.
REQ-011 i_ready  in  1  downstream accepts o_data when o_valid and i_ready are both high.
REQ-012 o_count  out  $clog2(DEPTH)+1  tuples held, including the output register.
REQ-013 o_overflow  out  1  sticky error: tuple arrived while full.

Function
REQ-014 Write event: i_stall low and count < DEPTH at posedge; tuple is stored in arrival order.
REQ-015 Read event: o_valid and i_ready high at posedge; head is removed.
REQ-016 Output is first-word-fall-through: a tuple written into an empty buffer at edge N appears on o_data with o_valid high after edge N.
REQ-017 o_data and o_valid change only on posedge; o_data holds stable while o_valid high and i_ready low.
REQ-018 Simultaneous read and write: both happen; count unchanged; permitted when full and when count is 1.
REQ-019 Write when count = DEPTH and no read in the same cycle: tuple is dropped; o_overflow is set and stays set until reset.
REQ-020 Read with o_valid low is ignored; count never underflows.
REQ-021 o_count equals the committed count after each edge: +1 on write only, -1 on read only, unchanged otherwise.
REQ-022 o_stall_req is registered; after each edge it equals (next count >= DEPTH - AF_MARGIN).
REQ-023 With the network's 2-cycle latency plus one registered cycle, AF_MARGIN >= 4 guarantees no overflow; overflow signals a system bug, not normal flow.
REQ-024 Storage pointers wrap modulo DEPTH; full and empty are distinguished by count, not pointer equality.
REQ-025 Element order inside a tuple is passed through unchanged; no comparison is done in this block.

Reset
REQ-026 While i_rst_n is low: pointers 0, count 0, o_valid 0, o_data 0, o_stall_req 0, o_overflow 0.
REQ-027 Reset mid-operation discards all held tuples.
REQ-028 No write or read event occurs at the first edge after i_rst_n rises if i_stall is high.

Structure
REQ-029 Shared package merger_pkg holds the DATA_WIDTH default, the tuple typedef (2*DATA_WIDTH) and the AF_MARGIN default.
REQ-030 Storage is one sub-module, merger_fifo_mem: DEPTH x 2*DATA_WIDTH, one write port, one registered read port.
REQ-031 Pointer, count, FWFT output register and flag logic live in merger_output_buffer.

Verification
REQ-032 Reset, then i_stall=0 for one cycle with i_elems={5,3}, i_ready=0 -> o_valid=1, o_data={5,3}, o_count=1 after that edge.
REQ-033 Write 16 tuples 1..16 with i_ready=0 -> o_stall_req rises after the 12th write; o_count=16; o_overflow=0; then i_ready=1 -> outputs 1..16 in order.
REQ-034 Full (16), write and read in the same cycle -> count stays 16, o_overflow=0, new tuple read out last.
REQ-035 Full (16), write with i_ready=0 -> o_overflow=1, count 16; the tuple is absent from the output stream.
REQ-036 Random i_stall and i_ready for 10k cycles, with the upstream model honouring o_stall_req after 3 cycles -> no overflow; output equals the input sequence.
REQ-037 Reset asserted with count=7 -> all outputs 0 immediately; o_valid stays 0 after release until the next write.
